io_timer_responder: RTL

- Memory-mapped interval-timer peripheral on the CPU's IO bus (io_cs/io_rd/io_wr, io_address, io_d_in, io_out).
- It is the responder end of CPU IO transactions.
- It is also the initiator of the intr/inta interrupt handshake toward the CPU.
- It counts down a programmable value, flags expiry, and requests an interrupt. It holds the request until the CPU acknowledges with inta and software clears the pending flag.

---
 rtl/io_timer_responder_if.sv | 22 ++
 rtl/io_timer_responder.sv | 127 ++++++++++++
 2 files changed

// File: rtl/io_timer_responder_if.sv
// CPU IO bus plus interrupt handshake between the CPU and the interval timer.
// io_out is not carried here; the timer drives it as a tri-state top-level
// port so the bus can float when the timer is not the selected responder.
interface io_timer_responder_if;
  logic        io_cs;
  logic        io_rd;
  logic        io_wr;
  logic [31:0] io_address;
  logic [31:0] io_d_in;
  logic        intr;
  logic        inta;

  modport master (
    output io_cs, io_rd, io_wr, io_address, io_d_in, inta,
    input  intr
  );

  modport slave (
    input  io_cs, io_rd, io_wr, io_address, io_d_in, inta,
    output intr
  );
endinterface

// File: rtl/io_timer_responder.sv
// Memory-mapped interval timer: prescaled down-counter with auto-reload,
// sticky pending flag and an intr/inta request/acknowledge handshake.
//
//   state      | meaning
//   -----------+--------------------------------------------------------
//   ST_IDLE    | no request outstanding, intr low
//   ST_REQ     | PEND & IE seen, intr high, waiting for inta
//   ST_SERVICE | CPU acknowledged; INSVC high until software clears PEND
module io_timer_responder #(
  parameter logic [31:0] BASE     = 32'h0000_0100,
  parameter int unsigned PRESCALE = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  io_timer_responder_if.slave    bus,
  output logic [31:0]            io_out
);

  localparam logic [1:0]  ST_IDLE    = 2'd0;
  localparam logic [1:0]  ST_REQ     = 2'd1;
  localparam logic [1:0]  ST_SERVICE = 2'd2;
  localparam logic [31:0] PC_LAST    = 32'(PRESCALE - 1);

  logic [2:0]  ctrl_q;     // {IE, AUTO, EN}
  logic [31:0] load_q;
  logic [31:0] count_q;
  logic        pend_q;
  logic [31:0] pc_q;
  logic [1:0]  state_q;
  logic [1:0]  state_nxt;
  logic        intr_q;
  logic [31:0] rd_data;

  logic       sel;
  logic       we;
  logic [1:0] idx;
  logic       tick;
  logic       expire;
  logic       insvc;

  // Byte lane bits of the address do not take part in decoding.
  logic unused_addr_lsb;
  assign unused_addr_lsb = &{1'b0, bus.io_address[1:0]};

  assign sel    = bus.io_cs && (bus.io_address[31:4] == BASE[31:4]);
  assign we     = sel && bus.io_wr;
  assign idx    = bus.io_address[3:2];
  assign tick   = ctrl_q[0] && (pc_q == PC_LAST);
  assign expire = tick && (count_q == 32'd0);
  assign insvc  = (state_q == ST_SERVICE);

  // Register read mux; reads show the pre-write value of this cycle.
  always_comb begin
    rd_data = 32'd0;
    case (idx)
      2'd0:    rd_data = {29'd0, ctrl_q};
      2'd1:    rd_data = load_q;
      2'd2:    rd_data = count_q;
      default: rd_data = {30'd0, insvc, pend_q};
    endcase
  end

  assign io_out  = (sel && bus.io_rd) ? rd_data : 32'hz;
  assign bus.intr = intr_q;

  // Prescaler: free-runs 0..PRESCALE-1 while enabled, parked at 0 otherwise.
  always_ff @(posedge clk) begin
    if (reset || !ctrl_q[0] || tick) pc_q <= 32'd0;
    else                             pc_q <= pc_q + 32'd1;
  end

  // CTRL: software write wins over the one-shot auto-clear of EN.
  always_ff @(posedge clk) begin
    if (reset)                          ctrl_q    <= 3'd0;
    else if (we && idx == 2'd0)         ctrl_q    <= bus.io_d_in[2:0];
    else if (expire && !ctrl_q[1])      ctrl_q[0] <= 1'b0;
  end

  // LOAD: plain software register.
  always_ff @(posedge clk) begin
    if (reset)                  load_q <= 32'd0;
    else if (we && idx == 2'd1) load_q <= bus.io_d_in;
  end

  // COUNT: software write wins over decrement and reload; holds at 0 in one-shot.
  always_ff @(posedge clk) begin
    if (reset)                  count_q <= 32'd0;
    else if (we && idx == 2'd2) count_q <= bus.io_d_in;
    else if (tick) begin
      if (count_q != 32'd0)     count_q <= count_q - 32'd1;
      else if (ctrl_q[1])       count_q <= load_q;
    end
  end

  // PEND: expiry wins over a write-1-to-clear in the same cycle.
  always_ff @(posedge clk) begin
    if (reset)                                       pend_q <= 1'b0;
    else if (expire)                                 pend_q <= 1'b1;
    else if (we && idx == 2'd3 && bus.io_d_in[0])    pend_q <= 1'b0;
  end

  // Interrupt handshake next-state; inta only matters while requesting.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE:    if (pend_q && ctrl_q[2]) state_nxt = ST_REQ;
      ST_REQ: begin
        if (!pend_q || !ctrl_q[2]) state_nxt = ST_IDLE;
        else if (bus.inta)         state_nxt = ST_SERVICE;
      end
      ST_SERVICE: if (!pend_q) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Handshake state and glitch-free registered intr.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      intr_q  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      intr_q  <= (state_nxt == ST_REQ);
    end
  end

endmodule
